// File: rtl/mips_md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// Imported by the top-level scheduler and by its arithmetic datapath.
package mips_md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_compute.sv
// Combinational product/quotient datapath: (op, a, b) -> {hi, lo, div_by_zero}.
// Signed division is done on magnitudes, so 0x80000000 / -1 needs no special case.
module md_compute
    import mips_md_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign signed_div  = (op == MD_DIV);
    assign a_mag       = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign b_mag       = (signed_div && b[31]) ? (~b + 32'd1) : b;
    assign b_safe      = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag       = a_mag / b_safe;
    assign r_mag       = a_mag % b_safe;
    assign div_by_zero = op[1] && (b == 32'd0);

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        unique case (op)
            MD_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
            end
            MD_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
            end
            MD_DIV: begin
                lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                hi = a[31] ? (~r_mag + 32'd1) : r_mag;
            end
            default: begin
                lo = q_mag;
                hi = r_mag;
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle mult/div scheduler holding the architectural HI/LO registers.
// Busy is registered and rises the cycle after Start; Flush aborts without touching HI/LO.
module mul_div_unit
    import mips_md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        WriteHI,
    input  logic        WriteLO,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t          state;
    md_op_t             op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div_by_zero;

    md_compute u_compute (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .hi          (res_hi),
        .lo          (res_lo),
        .div_by_zero (div_by_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= MD_MULT;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else if (Flush) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // Start beats a simultaneous mthi/mtlo.
                    if (Start) begin
                        state <= S_RUN;
                        Busy  <= 1'b1;
                        op_q  <= md_op_t'(MDOp);
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= MDOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else begin
                        if (WriteHI) HI <= A;
                        if (WriteLO) LO <= A;
                    end
                end
                default: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                        if (!div_by_zero) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, busy lengths,
// flush/reset aborts and Start/write priority cases.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        WriteHI;
    logic        WriteLO;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    int cyc;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mul_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .WriteHI (WriteHI),
        .WriteLO (WriteLO),
        .Flush   (Flush),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one Start cycle; returns at the negedge just after the launch edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (Busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic writeHiLo(input logic hiEn, input logic loEn, input logic [31:0] a);
        @(negedge clk);
        WriteHI = hiEn;
        WriteLO = loEn;
        A       = a;
        @(negedge clk);
        WriteHI = 1'b0;
        WriteLO = 1'b0;
        A       = 32'd0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = 2'b00; A = 32'd0; B = 32'd0;
        WriteHI = 1'b0; WriteLO = 1'b0; Flush = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(Busy), 64'd0);
        checkOutput("reset_hi", 64'(HI), 64'd0);
        checkOutput("reset_lo", 64'(LO), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Arithmetic cases with full busy-length checks.
        applyStimulus(OP_MULT, 32'hFFFFFFFF, 32'd2);
        waitIdle(cyc);
        checkOutput("mult_cycles", 64'(cyc), 64'd5);
        checkOutput("mult_hi", 64'(HI), 64'hFFFFFFFF);
        checkOutput("mult_lo", 64'(LO), 64'hFFFFFFFE);

        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        waitIdle(cyc);
        checkOutput("multu_cycles", 64'(cyc), 64'd5);
        checkOutput("multu_hi", 64'(HI), 64'h00000001);
        checkOutput("multu_lo", 64'(LO), 64'hFFFFFFFE);

        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2);
        waitIdle(cyc);
        checkOutput("div_cycles", 64'(cyc), 64'd10);
        checkOutput("div_hi", 64'(HI), 64'hFFFFFFFF);
        checkOutput("div_lo", 64'(LO), 64'hFFFFFFFD);

        applyStimulus(OP_DIVU, 32'd7, 32'd2);
        waitIdle(cyc);
        checkOutput("divu_cycles", 64'(cyc), 64'd10);
        checkOutput("divu_hi", 64'(HI), 64'd1);
        checkOutput("divu_lo", 64'(LO), 64'd3);

        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        waitIdle(cyc);
        checkOutput("div_ovf_hi", 64'(HI), 64'd0);
        checkOutput("div_ovf_lo", 64'(LO), 64'h80000000);

        // mthi/mtlo, including both at once, then divide by zero.
        writeHiLo(1'b1, 1'b1, 32'h33);
        checkOutput("mthilo_both_hi", 64'(HI), 64'h33);
        checkOutput("mthilo_both_lo", 64'(LO), 64'h33);
        writeHiLo(1'b1, 1'b0, 32'h11);
        checkOutput("mthi_hi", 64'(HI), 64'h11);
        checkOutput("mthi_lo_kept", 64'(LO), 64'h33);
        writeHiLo(1'b0, 1'b1, 32'h22);
        checkOutput("mtlo_lo", 64'(LO), 64'h22);

        applyStimulus(OP_DIV, 32'd5, 32'd0);
        waitIdle(cyc);
        checkOutput("div0_cycles", 64'(cyc), 64'd10);
        checkOutput("div0_hi", 64'(HI), 64'h11);
        checkOutput("div0_lo", 64'(LO), 64'h22);

        // Flush at busy cycle 4 of a divu.
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        checkOutput("flush_busy", 64'(Busy), 64'd0);
        repeat (12) @(negedge clk);
        checkOutput("flush_busy_late", 64'(Busy), 64'd0);
        checkOutput("flush_hi", 64'(HI), 64'h11);
        checkOutput("flush_lo", 64'(LO), 64'h22);

        // Flush in IDLE blocks both Start and writes.
        @(negedge clk);
        Start = 1'b1; Flush = 1'b1; WriteHI = 1'b1; MDOp = OP_MULT; A = 32'h99; B = 32'd3;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0; WriteHI = 1'b0; A = 32'd0; B = 32'd0;
        checkOutput("idle_flush_busy", 64'(Busy), 64'd0);
        checkOutput("idle_flush_hi", 64'(HI), 64'h11);
        repeat (6) @(negedge clk);
        checkOutput("idle_flush_lo", 64'(LO), 64'h22);

        // Start beats simultaneous writes in IDLE.
        @(negedge clk);
        Start = 1'b1; WriteHI = 1'b1; WriteLO = 1'b1; MDOp = OP_MULT; A = 32'h10; B = 32'h10;
        @(negedge clk);
        Start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0; A = 32'd0; B = 32'd0;
        checkOutput("startwin_hi_mid", 64'(HI), 64'h11);
        checkOutput("startwin_lo_mid", 64'(LO), 64'h22);
        waitIdle(cyc);
        checkOutput("startwin_cycles", 64'(cyc), 64'd5);
        checkOutput("startwin_hi", 64'(HI), 64'd0);
        checkOutput("startwin_lo", 64'(LO), 64'h100);

        // Start and WriteHI during RUN are ignored.
        applyStimulus(OP_MULT, 32'd3, 32'd4);
        @(negedge clk);
        Start = 1'b1; WriteHI = 1'b1; MDOp = OP_DIVU; A = 32'h55; B = 32'd1;
        @(negedge clk);
        Start = 1'b0; WriteHI = 1'b0; A = 32'd0; B = 32'd0;
        waitIdle(cyc);
        checkOutput("run_ignore_cycles", 64'(cyc + 2), 64'd5);
        checkOutput("run_ignore_hi", 64'(HI), 64'd0);
        checkOutput("run_ignore_lo", 64'(LO), 64'd12);

        // Start on the completion edge is dropped.
        applyStimulus(OP_MULT, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        Start = 1'b1; MDOp = OP_MULT; A = 32'd7; B = 32'd7;
        @(negedge clk);
        Start = 1'b0; A = 32'd0; B = 32'd0;
        checkOutput("complete_start_busy", 64'(Busy), 64'd0);
        checkOutput("complete_start_lo", 64'(LO), 64'd6);
        repeat (6) @(negedge clk);
        checkOutput("complete_start_busy_late", 64'(Busy), 64'd0);
        checkOutput("complete_start_lo_late", 64'(LO), 64'd6);

        writeHiLo(1'b1, 1'b0, 32'h55);
        checkOutput("idle_mthi_hi", 64'(HI), 64'h55);
        checkOutput("idle_mthi_lo", 64'(LO), 64'd6);

        // Asynchronous reset in busy cycle 3 of a div.
        applyStimulus(OP_DIV, 32'd100, 32'd3);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_busy", 64'(Busy), 64'd0);
        checkOutput("async_reset_hi", 64'(HI), 64'd0);
        checkOutput("async_reset_lo", 64'(LO), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("post_reset_busy", 64'(Busy), 64'd0);
        checkOutput("post_reset_hi", 64'(HI), 64'd0);
        checkOutput("post_reset_lo", 64'(LO), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide scheduler for the P6 pipelined MIPS core. It sits in the EX stage beside the single-cycle ALU. It accepts mult/multu/div/divu from the EX stage and sequences them over a fixed number of cycles, holding the HI/LO architectural registers. It drives `Busy` so the hazard unit can stall mfhi/mflo/mthi/mtlo and further md ops. It also supports cancellation of an in-flight operation on an exception flush.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration of mult/multu. Must be ≥1.
- `DIV_CYCLES`, default 10: busy duration of div/divu. Must be ≥1.

Ports:
- `clk`  in  1  single clock. Everything samples on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  launch the op in `MDOp` using `A`/`B`.
- `MDOp`  in  2  operation code: 00 mult, 01 multu, 10 div, 11 divu.
- `A`, `B`  in  32 each  operands (rs, rt), sampled at the `Start` edge.
- `WriteHI`, `WriteLO`  in  1 each  mthi/mtlo write enables; the data is `A`.
- `Flush`  in  1  abort the in-flight op and ignore `Start` this cycle.
- `Busy`  out  1  registered; high while an op is in flight.
- `HI`, `LO`  out  32 each  registered architectural HI/LO.

## Operation
States:
- IDLE: `Busy`=0.
- RUN: `Busy`=1. The down-counter `cnt` holds the remaining cycles; its width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Transitions:
- IDLE → RUN on an edge with `Start`=1 and `Flush`=0. On that edge:
  - latch the opcode and both operands;
  - load `cnt` = MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu;
  - `HI`/`LO` stay unchanged.
- RUN, `cnt`>1 → RUN with `cnt`-1.
- RUN, `cnt`==1 → IDLE, and `HI`/`LO` take the result on that same edge.
- RUN with `Flush`=1 → IDLE on that edge. The result is discarded and `HI`/`LO` are unchanged.

Arithmetic, computed from the latched operands:
- mult: 64-bit signed product; HI = [63:32], LO = [31:0].
- multu: 64-bit unsigned product; HI = [63:32], LO = [31:0].
- div: LO = signed quotient, truncated toward zero. HI = remainder, which carries the sign of the dividend.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divisor 0 (div or divu): the op still takes DIV_CYCLES and `Busy` behaves normally. At completion `HI` and `LO` are left unchanged.
- div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No exception is raised.

mthi/mtlo:
- In IDLE, `WriteHI` loads `HI` ← `A` and `WriteLO` loads `LO` ← `A` on the next edge. Both may be asserted in the same cycle.
- In RUN, `WriteHI`/`WriteLO` are ignored. The hazard unit guarantees they are never issued while `Busy`=1.

Priority and boundary cases:
- `Start` while RUN is ignored. No restart occurs and the latched operands are kept.
- `Start` together with `WriteHI`/`WriteLO` in IDLE: `Start` wins and the writes are dropped.
- `Flush` has priority over everything else: no start, no write, and any in-flight op is aborted.
- The completion edge coinciding with `Start`: the unit goes to IDLE, and this `Start` is ignored because it arrived while RUN.
- Reset, asserted at any time including mid-operation: state = IDLE, `Busy`=0, `HI`=`LO`=0, `cnt`=0, latched operands cleared. The effect is immediate (asynchronous).

## Timing
- `Start` sampled at edge t0 → `Busy` is high from just after t0 through edge t0+N. It is high for exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
- `HI`/`LO` hold the new value just after edge t0+N, and `Busy` falls at the same edge.
- The earliest next `Start` is accepted at edge t0+N+1.
- mthi/mtlo have 1-cycle latency: assert in cycle c, and the new value is visible in cycle c+1.
- Outputs are glitch-free registers. No output depends combinationally on any input.
- `Busy` does not rise in the same cycle as `Start`. The hazard unit must stall on (`Start` | `Busy`).

## Structure
- Shared package `mips_md_pkg` holds:
  - the `MDOp` encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state encodings S_IDLE and S_RUN;
  - the default cycle-count constants.
- One combinational sub-module, `md_compute`: (op, a, b) → {hi, lo, div_by_zero}. It performs the product and quotient math.
- The top level holds the FSM, counter, operand latches and the HI/LO registers.

## Test plan
- Reset with clocking: `Busy`=0, `HI`=`LO`=0. Asserting `reset` while in RUN at cycle 3 of a div → `Busy`=0 at once, `HI`/`LO`=0, and no later write occurs.
- mult with A=0xFFFFFFFF, B=2 → `Busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. The same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2 → 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 → LO=3, HI=1.
- div with B=0, after preloading HI=0x11, LO=0x22 via mthi/mtlo → 10 busy cycles, then HI=0x11, LO=0x22 unchanged.
- Start a divu, assert `Flush` at busy cycle 4 → `Busy`=0 the next cycle and HI/LO unchanged. `Start` with `Flush` asserted in IDLE → `Busy` stays 0.
- `Start` pulsed during RUN, and `WriteHI`=1 with A=0x55 during RUN → both ignored, and the result matches the first op. `WriteHI`=1 with A=0x55 in IDLE → HI=0x55 one cycle later.
